// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: control codes, supported-code check and the
// arbiter state encoding, so the ALU and its arbiter cannot disagree.
package alu_defs;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_LSL   = 4'b0011;
  localparam logic [3:0] ALU_LSR   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  function automatic logic is_supported(input logic [3:0] ctrl);
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_LSL,
      ALU_LSR, ALU_SUB, ALU_PASSB: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant. The pointer names the favoured requester on a
// tie and moves to the other requester when the owner's response completes.
module rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic upd_i,
  input  logic owner_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (req0_i && req1_i) begin
      gnt0_o = ~ptr_q;
      gnt1_o = ptr_q;
    end else begin
      gnt0_o = req0_i;
      gnt1_o = req1_i;
    end
    ptr_d = upd_i ? ~owner_i : ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one unclocked 64-bit ALU between execute (port 0) and the
// branch/address unit (port 1); operands are held SETTLE cycles before capture.
module alu_arbiter
  import alu_defs::*;
#(
  parameter int n      = 64,
  parameter int SETTLE = 3
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Req0Valid,
  output logic         Req0Ready,
  input  logic [n-1:0] Req0A,
  input  logic [n-1:0] Req0B,
  input  logic [3:0]   Req0Ctrl,
  output logic         Resp0Valid,
  input  logic         Resp0Ready,
  output logic [n-1:0] Resp0W,
  output logic         Resp0Zero,
  output logic         Resp0Err,
  input  logic         Req1Valid,
  output logic         Req1Ready,
  input  logic [n-1:0] Req1A,
  input  logic [n-1:0] Req1B,
  input  logic [3:0]   Req1Ctrl,
  output logic         Resp1Valid,
  input  logic         Resp1Ready,
  output logic [n-1:0] Resp1W,
  output logic         Resp1Zero,
  output logic         Resp1Err,
  output logic [n-1:0] AluA,
  output logic [n-1:0] AluB,
  output logic [3:0]   AluCtrl,
  input  logic [n-1:0] AluW,
  input  logic         AluZero
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic [n-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]    alu_ctrl_q, alu_ctrl_d;
  logic [1:0]    rvalid_q, rvalid_d, rerr_q, rerr_d, rzero_q, rzero_d;
  logic [n-1:0]  rw_q [2];
  logic [n-1:0]  rw_d [2];

  logic          gnt0, gnt1, arb_upd, resp_rdy;
  logic [n-1:0]  sel_a, sel_b;
  logic [3:0]    sel_ctrl;

  rr_arb2 u_arb (
    .clk_i   (CLK),
    .rst_i   (Reset),
    .req0_i  (Req0Valid),
    .req1_i  (Req1Valid),
    .upd_i   (arb_upd),
    .owner_i (owner_q),
    .gnt0_o  (gnt0),
    .gnt1_o  (gnt1)
  );

  assign Req0Ready = (state_q == ST_IDLE) && gnt0;
  assign Req1Ready = (state_q == ST_IDLE) && gnt1;
  assign sel_a     = gnt1 ? Req1A    : Req0A;
  assign sel_b     = gnt1 ? Req1B    : Req0B;
  assign sel_ctrl  = gnt1 ? Req1Ctrl : Req0Ctrl;
  assign resp_rdy  = owner_q ? Resp1Ready : Resp0Ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    rvalid_d   = rvalid_q;
    rerr_d     = rerr_q;
    rzero_d    = rzero_q;
    rw_d       = rw_q;
    arb_upd    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Req0Ready || Req1Ready) begin
          owner_d = gnt1;
          if (is_supported(sel_ctrl)) begin
            alu_a_d    = sel_a;
            alu_b_d    = sel_b;
            alu_ctrl_d = sel_ctrl;
            cnt_d      = '0;
            state_d    = ST_ISSUE;
          end else begin
            // Unsupported op never touches the ALU; answer immediately.
            rvalid_d[gnt1] = 1'b1;
            rerr_d[gnt1]   = 1'b1;
            rzero_d[gnt1]  = 1'b0;
            rw_d[gnt1]     = '0;
            state_d        = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(SETTLE - 1)) begin
          rw_d[owner_q]     = AluW;
          rzero_d[owner_q]  = AluZero;
          rvalid_d[owner_q] = 1'b1;
          state_d           = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_rdy) begin
          rvalid_d[owner_q] = 1'b0;
          rerr_d[owner_q]   = 1'b0;
          arb_upd           = 1'b1;
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= 4'b0000;
      rvalid_q   <= '0;
      rerr_q     <= '0;
      rzero_q    <= '0;
      rw_q[0]    <= '0;
      rw_q[1]    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      rvalid_q   <= rvalid_d;
      rerr_q     <= rerr_d;
      rzero_q    <= rzero_d;
      rw_q[0]    <= rw_d[0];
      rw_q[1]    <= rw_d[1];
    end
  end

  assign AluA       = alu_a_q;
  assign AluB       = alu_b_q;
  assign AluCtrl    = alu_ctrl_q;
  assign Resp0Valid = rvalid_q[0];
  assign Resp1Valid = rvalid_q[1];
  assign Resp0Err   = rerr_q[0];
  assign Resp1Err   = rerr_q[1];
  assign Resp0Zero  = rzero_q[0];
  assign Resp1Zero  = rzero_q[1];
  assign Resp0W     = rw_q[0];
  assign Resp1W     = rw_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 64-bit ALU on the ALU side.
module tb_alu_arbiter;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Req0Valid = 1'b0, Req1Valid = 1'b0;
  logic        Req0Ready, Req1Ready;
  logic [63:0] Req0A = '0, Req0B = '0, Req1A = '0, Req1B = '0;
  logic [3:0]  Req0Ctrl = '0, Req1Ctrl = '0;
  logic        Resp0Valid, Resp1Valid;
  logic        Resp0Ready = 1'b0, Resp1Ready = 1'b0;
  logic [63:0] Resp0W, Resp1W;
  logic        Resp0Zero, Resp1Zero, Resp0Err, Resp1Err;
  logic [63:0] AluA, AluB, AluW;
  logic [3:0]  AluCtrl;
  logic        AluZero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.n(64), .SETTLE(3)) dut (
    .CLK(CLK), .Reset(Reset),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0A(Req0A), .Req0B(Req0B), .Req0Ctrl(Req0Ctrl),
    .Resp0Valid(Resp0Valid), .Resp0Ready(Resp0Ready), .Resp0W(Resp0W), .Resp0Zero(Resp0Zero), .Resp0Err(Resp0Err),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1A(Req1A), .Req1B(Req1B), .Req1Ctrl(Req1Ctrl),
    .Resp1Valid(Resp1Valid), .Resp1Ready(Resp1Ready), .Resp1W(Resp1W), .Resp1Zero(Resp1Zero), .Resp1Err(Resp1Err),
    .AluA(AluA), .AluB(AluB), .AluCtrl(AluCtrl), .AluW(AluW), .AluZero(AluZero)
  );

  // Behavioural stand-in for the unclocked external ALU.
  always_comb begin
    AluW = '0;
    case (AluCtrl)
      4'b0000: AluW = AluA & AluB;
      4'b0001: AluW = AluA | AluB;
      4'b0010: AluW = AluA + AluB;
      4'b0011: AluW = AluA << AluB[5:0];
      4'b0100: AluW = AluA >> AluB[5:0];
      4'b0110: AluW = AluA - AluB;
      4'b0111: AluW = AluB;
      default: AluW = '0;
    endcase
  end
  assign AluZero = (AluW == 64'd0);

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
    #1;
    n_cmp++; if (Req0Ready !== 1'b0 || Req1Ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b%b want 00", Req0Ready, Req1Ready); end
    n_cmp++; if (Resp0Valid !== 1'b0 || Resp1Valid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b%b want 00", Resp0Valid, Resp1Valid); end
    n_cmp++; if (AluA !== 64'd0 || AluB !== 64'd0 || AluCtrl !== 4'd0) begin n_bad++; $display("FAIL rst_alu: got %h %h %h want zeros", AluA, AluB, AluCtrl); end
    n_cmp++; if (Resp0W !== 64'd0 || Resp1W !== 64'd0 || Resp0Err !== 1'b0 || Resp1Err !== 1'b0 || Resp0Zero !== 1'b0 || Resp1Zero !== 1'b0) begin n_bad++; $display("FAIL rst_resp: got W %h %h err %b%b zero %b%b want zeros", Resp0W, Resp1W, Resp0Err, Resp1Err, Resp0Zero, Resp1Zero); end
  endtask

  task automatic test_add();
    Req0Valid = 1'b1; Req0A = 64'd5; Req0B = 64'd7; Req0Ctrl = 4'b0010;
    #1;
    n_cmp++; if (Req0Ready !== 1'b1) begin n_bad++; $display("FAIL add_ready: got %b want 1", Req0Ready); end
    step();
    Req0Valid = 1'b0;
    #1;
    n_cmp++; if (Req0Ready !== 1'b0) begin n_bad++; $display("FAIL add_ready_drop: got %b want 0", Req0Ready); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (AluCtrl !== 4'b0010 || AluA !== 64'd5 || AluB !== 64'd7) begin n_bad++; $display("FAIL add_hold: got ctrl %b A %0d B %0d want 0010 5 7", AluCtrl, AluA, AluB); end
      n_cmp++; if (Resp0Valid !== 1'b0) begin n_bad++; $display("FAIL add_early: got %b want 0", Resp0Valid); end
      step();
    end
    n_cmp++; if (Resp0Valid !== 1'b0) begin n_bad++; $display("FAIL add_early3: got %b want 0", Resp0Valid); end
    step();
    n_cmp++; if (Resp0Valid !== 1'b1) begin n_bad++; $display("FAIL add_rvalid: got %b want 1", Resp0Valid); end
    n_cmp++; if (Resp0W !== 64'd12 || Resp0Zero !== 1'b0 || Resp0Err !== 1'b0) begin n_bad++; $display("FAIL add_result: got W %0d Z %b E %b want 12 0 0", Resp0W, Resp0Zero, Resp0Err); end
    Resp0Ready = 1'b1;
    step();
    Resp0Ready = 1'b0;
    n_cmp++; if (Resp0Valid !== 1'b0 || Resp0W !== 64'd12) begin n_bad++; $display("FAIL add_after: got V %b W %0d want 0 12", Resp0Valid, Resp0W); end
  endtask

  task automatic test_sub_hold();
    Req0Valid = 1'b1; Req0A = 64'd9; Req0B = 64'd9; Req0Ctrl = 4'b0110;
    #1;
    n_cmp++; if (Req0Ready !== 1'b1) begin n_bad++; $display("FAIL sub_ready: got %b want 1", Req0Ready); end
    step();
    Req0Valid = 1'b0;
    Req1Valid = 1'b1; Req1A = 64'd1; Req1B = 64'd1; Req1Ctrl = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (Req1Ready !== 1'b0 || AluCtrl !== 4'b0110) begin n_bad++; $display("FAIL sub_issue: got r1rdy %b ctrl %b want 0 0110", Req1Ready, AluCtrl); end
      step();
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (Resp0Valid !== 1'b1 || Resp0W !== 64'd0 || Resp0Zero !== 1'b1) begin n_bad++; $display("FAIL sub_hold: got V %b W %0d Z %b want 1 0 1", Resp0Valid, Resp0W, Resp0Zero); end
      n_cmp++; if (Req1Ready !== 1'b0 || Resp1Valid !== 1'b0) begin n_bad++; $display("FAIL sub_block1: got r1rdy %b r1valid %b want 0 0", Req1Ready, Resp1Valid); end
      step();
    end
    Resp0Ready = 1'b1;
    step();
    Resp0Ready = 1'b0;
    n_cmp++; if (Req1Ready !== 1'b1 || Resp0Valid !== 1'b0) begin n_bad++; $display("FAIL sub_grant1: got r1rdy %b r0valid %b want 1 0", Req1Ready, Resp0Valid); end
    step();
    Req1Valid = 1'b0;
    step(); step(); step();
    n_cmp++; if (Resp1Valid !== 1'b1 || Resp1W !== 64'd2) begin n_bad++; $display("FAIL sub_resp1: got V %b W %0d want 1 2", Resp1Valid, Resp1W); end
    Resp1Ready = 1'b1;
    step();
    Resp1Ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic        own;
    logic [63:0] exp_w;
    logic [3:0]  exp_c;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    Req0Valid = 1'b1; Req0A = 64'd1;    Req0B = 64'd4;    Req0Ctrl = 4'b0011;
    Req1Valid = 1'b1; Req1A = 64'hF0;   Req1B = 64'h0F;   Req1Ctrl = 4'b0001;
    Resp0Ready = 1'b1; Resp1Ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      own   = (k % 2) == 1;
      exp_w = own ? 64'hFF : 64'd16;
      exp_c = own ? 4'b0001 : 4'b0011;
      #1;
      n_cmp++; if (Req0Ready !== ~own || Req1Ready !== own) begin n_bad++; $display("FAIL b2b_grant%0d: got %b%b want owner %b", k, Req1Ready, Req0Ready, own); end
      step();
      n_cmp++; if (AluCtrl !== exp_c) begin n_bad++; $display("FAIL b2b_ctrl%0d: got %b want %b", k, AluCtrl, exp_c); end
      step(); step(); step();
      n_cmp++; if (Resp0Valid !== ~own || Resp1Valid !== own) begin n_bad++; $display("FAIL b2b_rvalid%0d: got %b%b want owner %b", k, Resp1Valid, Resp0Valid, own); end
      n_cmp++; if ((own ? Resp1W : Resp0W) !== exp_w) begin n_bad++; $display("FAIL b2b_w%0d: got %h want %h", k, own ? Resp1W : Resp0W, exp_w); end
      step();
    end
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    Resp0Ready = 1'b0; Resp1Ready = 1'b0;
  endtask

  task automatic test_unsupported();
    Req1Valid = 1'b1; Req1A = 64'd3; Req1B = 64'd4; Req1Ctrl = 4'b0101;
    #1;
    n_cmp++; if (Req1Ready !== 1'b1) begin n_bad++; $display("FAIL unsup_ready: got %b want 1", Req1Ready); end
    step();
    Req1Valid = 1'b0;
    n_cmp++; if (Resp1Valid !== 1'b1 || Resp1Err !== 1'b1 || Resp1W !== 64'd0 || Resp1Zero !== 1'b0) begin n_bad++; $display("FAIL unsup_resp: got V %b E %b W %h Z %b want 1 1 0 0", Resp1Valid, Resp1Err, Resp1W, Resp1Zero); end
    n_cmp++; if (AluA !== 64'hF0 || AluB !== 64'h0F || AluCtrl !== 4'b0001) begin n_bad++; $display("FAIL unsup_alu: got %h %h %b want f0 0f 0001", AluA, AluB, AluCtrl); end
    Resp1Ready = 1'b1;
    step();
    Resp1Ready = 1'b0;
    n_cmp++; if (Resp1Valid !== 1'b0 || Resp1Err !== 1'b0) begin n_bad++; $display("FAIL unsup_clear: got V %b E %b want 0 0", Resp1Valid, Resp1Err); end
  endtask

  task automatic test_lsr_and();
    logic [63:0] a_t [2];
    logic [63:0] b_t [2];
    logic [3:0]  c_t [2];
    logic [63:0] w_t [2];
    logic        z_t [2];
    a_t[0] = 64'h8000_0000_0000_0000; b_t[0] = 64'd63;   c_t[0] = 4'b0100; w_t[0] = 64'd1; z_t[0] = 1'b0;
    a_t[1] = 64'hF0;                  b_t[1] = 64'h0F;   c_t[1] = 4'b0000; w_t[1] = 64'd0; z_t[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      Req0Valid = 1'b1; Req0A = a_t[k]; Req0B = b_t[k]; Req0Ctrl = c_t[k];
      #1;
      n_cmp++; if (Req0Ready !== 1'b1) begin n_bad++; $display("FAIL lsr_and_ready%0d: got %b want 1", k, Req0Ready); end
      step();
      Req0Valid = 1'b0;
      step(); step(); step();
      n_cmp++; if (Resp0Valid !== 1'b1 || Resp0W !== w_t[k] || Resp0Zero !== z_t[k]) begin n_bad++; $display("FAIL lsr_and_resp%0d: got V %b W %h Z %b want 1 %h %b", k, Resp0Valid, Resp0W, Resp0Zero, w_t[k], z_t[k]); end
      Resp0Ready = 1'b1;
      step();
      Resp0Ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    Req0Valid = 1'b1; Req0A = 64'd0; Req0B = 64'h1234; Req0Ctrl = 4'b0111;
    #1;
    n_cmp++; if (Req0Ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b want 1", Req0Ready); end
    step();
    Req0Valid = 1'b0;
    n_cmp++; if (AluB !== 64'h1234) begin n_bad++; $display("FAIL rmid_issue: got %h want 1234", AluB); end
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    n_cmp++; if (AluA !== 64'd0 || AluB !== 64'd0 || AluCtrl !== 4'd0 || Resp0Valid !== 1'b0 || Resp0W !== 64'd0) begin n_bad++; $display("FAIL rmid_reset: got A %h B %h C %b V %b W %h want zeros", AluA, AluB, AluCtrl, Resp0Valid, Resp0W); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (Resp0Valid !== 1'b0) begin n_bad++; $display("FAIL rmid_noresp: got %b want 0", Resp0Valid); end
    end
    Req0Valid = 1'b1;
    Req1Valid = 1'b1; Req1A = 64'd1; Req1B = 64'd1; Req1Ctrl = 4'b0010;
    #1;
    n_cmp++; if (Req0Ready !== 1'b1 || Req1Ready !== 1'b0) begin n_bad++; $display("FAIL rmid_ptr: got %b%b want 01", Req1Ready, Req0Ready); end
    step();
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    step(); step(); step();
    n_cmp++; if (Resp0Valid !== 1'b1 || Resp0W !== 64'h1234) begin n_bad++; $display("FAIL rmid_passb: got V %b W %h want 1 1234", Resp0Valid, Resp0W); end
    Resp0Ready = 1'b1;
    step();
    Resp0Ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_hold();
    test_back_to_back();
    test_unsupported();
    test_lsr_and();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 64-bit ALU instance between two requesters: port 0 is the execute stage and port 1 is the branch/address unit.
- Round-robin arbitration with a valid/ready handshake on each request and each response.
- Registers the granted operands and control onto the ALU inputs and holds them for a fixed settle window, because the ALU output is unclocked and delayed.
- Captures the ALU result and Zero flag, then returns them to the requester that owns the transaction.

Parameters:
n, 64, operand/result width
SETTLE, 3, cycles ALU inputs are held before result capture (covers ALU output + Zero delay at nominal clock; must be >= 1)

Ports:
CLK  input  1  clock, rising edge
Reset  input  1  synchronous, active-high reset
Req0Valid  input  1  requester 0 has an operation
Req0Ready  output  1  requester 0 operation accepted this cycle
Req0A  input  n  operand A, requester 0
Req0B  input  n  operand B, requester 0
Req0Ctrl  input  4  ALU control code, requester 0
Resp0Valid  output  1  result available for requester 0
Resp0Ready  input  1  requester 0 consumes result
Resp0W  output  n  result, requester 0
Resp0Zero  output  1  zero flag, requester 0
Resp0Err  output  1  unsupported control code, requester 0
Req1Valid/Req1Ready/Req1A/Req1B/Req1Ctrl/Resp1Valid/Resp1Ready/Resp1W/Resp1Zero/Resp1Err  same as port 0, for requester 1
AluA  output  n  to ALU BusA (registered)
AluB  output  n  to ALU BusB (registered)
AluCtrl  output  4  to ALU ALUCtrl (registered)
AluW  input  n  from ALU BusW
AluZero  input  1  from ALU Zero

Behaviour:
- Reset (synchronous, active-high):
  - State to IDLE; priority pointer to 0; settle counter to 0.
  - AluA = 0, AluB = 0, AluCtrl = 4'b0000.
  - All ReqNReady, RespNValid and RespNErr are 0; RespNW = 0; RespNZero = 0.
  - Reset mid-transaction drops the transaction silently: no response is ever issued for it.
- Supported control codes: 0000 AND, 0001 OR, 0010 ADD, 0011 LSL, 0100 LSR, 0110 SUB, 0111 PassB. All other codes are unsupported.
- State machine: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - ReqNReady is combinational: 1 only for the requester selected by arbitration, and only when that requester's Valid is 1.
  - Arbitration: if exactly one Valid is high, grant it. If both are high, grant the requester the priority pointer names.
  - On a handshake (Valid && Ready), register A, B, Ctrl and the owner id.
  - Supported code: load AluA/AluB/AluCtrl, clear the counter, go to ISSUE.
  - Unsupported code: leave ALU inputs unchanged and go directly to RESP with Err = 1, W = 0, Zero = 0.
- ISSUE:
  - ALU inputs are held constant; the counter increments each cycle.
  - When counter == SETTLE-1, capture AluW/AluZero into the owner's RespW/RespZero on that edge and go to RESP.
  - The capture edge is SETTLE cycles after the cycle the ALU inputs first appear.
- RESP:
  - Owner's RespValid = 1 with W, Zero and Err stable; the non-owner's RespValid stays 0.
  - Hold until owner's RespReady = 1, then clear RespValid and Err, set the priority pointer to the other requester, and return to IDLE.
  - RespW/RespZero keep their last values after the handshake.
- Throughput and latency:
  - No new request is accepted outside IDLE; both ReqReady are 0 in ISSUE and RESP.
  - Request handshake to RespValid is SETTLE+1 cycles for a supported op, 1 cycle for an unsupported op.
  - With RespReady tied high, one op completes every SETTLE+2 cycles.
- Boundary conditions:
  - Both Valid high every cycle: grants strictly alternate 0,1,0,1 starting from 0 after reset.
  - Valid dropped before Ready: nothing is accepted, no state change.
  - RespReady asserted while RespValid = 0: ignored.
  - ALU inputs never change in ISSUE, whatever the requester ports are doing.

Decomposition:
- Shared package alu_defs holds:
  - The seven ALU control codes as named 4-bit constants.
  - An is_supported(ctrl) function.
  - The arbiter state encoding: IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2.
- ALU and arbiter both use alu_defs so codes cannot diverge.
- One sub-module: rr_arb2, a two-input round-robin grant with a priority-pointer register, plus an update strobe pulsed on response completion.

Test Plan:
- Reset, then port 0 only, Req0 ADD A=5 B=7 -> Req0Ready=1 for 1 cycle; AluCtrl=0010 held 3 cycles; Resp0Valid at cycle 4 with W=12, Zero=0, Err=0.
- Req0 SUB A=9 B=9, Resp0Ready held low 5 cycles -> Resp0Valid stays 1 with W=0, Zero=1; Req1Valid=1 meanwhile gets no Ready until after the Resp0 handshake.
- Both Valid continuously after reset, RespReady=1: port 0 LSL A=1 B=4, port 1 OR A=0xF0 B=0x0F -> grant order 0,1,0,1; Resp0W=16, Resp1W=0xFF; one completion every 5 cycles.
- Req1 with unsupported Ctrl=0101 -> Resp1Valid one cycle after the handshake with Err=1, W=0; AluA/AluB/AluCtrl unchanged.
- Reset asserted during ISSUE of Req0 PassB B=0x1234 -> no Resp0Valid; outputs at reset values next cycle; the next request is granted to port 0.
- Req0 LSR A=0x8000_0000_0000_0000 B=63 -> Resp0W=1, Zero=0; then AND A=0xF0 B=0x0F -> W=0, Zero=1.
